// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: adds two W = N*WORDS bit operands over WORDS cycles,
// reusing a single N-bit ripple slice built from full_adder cells and carrying
// between slices through a register. Handshaked with valid/ready on both sides.
// Optional subtract mode (port `sub`) is compiled in by defining SUB_MODE_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiword_adder_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
`ifdef SUB_MODE_EN
    input  logic                 sub,
`endif
    output logic                 busy
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      sum_r;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r;
    logic              cout_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              sub_r;
    logic              sub_s;
    logic              accept_s;
    logic [N-1:0]      a_slice_s;
    logic [N-1:0]      b_slice_s;
    logic [N-1:0]      s_slice_s;
    logic [N:0]        c_chain_s;

`ifdef SUB_MODE_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    assign accept_s  = (state_r == ST_IDLE) && in_valid;
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Select the current operand slices; B is inverted when subtracting.
    always_comb begin
        a_slice_s = a_r[idx_r*N +: N];
        if (sub_r) begin
            b_slice_s = ~b_r[idx_r*N +: N];
        end else begin
            b_slice_s = b_r[idx_r*N +: N];
        end
    end

    assign c_chain_s[0] = carry_r;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            full_adder u_fa (
                .a  (a_slice_s[gi]),
                .b  (b_slice_s[gi]),
                .ci (c_chain_s[gi]),
                .s  (s_slice_s[gi]),
                .co (c_chain_s[gi+1])
            );
        end
    endgenerate

    // Next-state logic for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered out_valid/busy decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s == ST_DONE);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Operand latch on accept, then one slice of sum and the inter-slice carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            sub_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            sum_r   <= {W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= sub_s;
            sub_r   <= sub_s;
        end else if (state_r == ST_RUN) begin
            sum_r[idx_r*N +: N] <= s_slice_s;
            carry_r             <= c_chain_s[N];
            idx_r               <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
                cout_r <= c_chain_s[N];
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            sum_r <= sum_r;
        end
    end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench for multiword_adder_seq (N=4, WORDS=4) plus a small
// N=8, WORDS=1 instance for the single-slice case.
module tb_multiword_adder_seq;
    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef logic [W:0] wv_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          sub = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready, out_valid, cout, busy;
    logic [W-1:0]  sum;

    logic          in_valid2 = 1'b0;
    logic [7:0]    a2 = 8'h00;
    logic [7:0]    b2 = 8'h00;
    logic          in_ready2, out_valid2, cout2, busy2;
    logic [7:0]    sum2;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    wv_t           exp_q[$];
    int            acc_q[$];
    bit            prev_ov = 1'b0;
    logic [W-1:0]  held_sum = '0;
    logic          held_cout = 1'b0;
    bit            rand_done = 1'b0;

    multiword_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef SUB_MODE_EN
        .sub(sub),
`endif
        .busy(busy)
    );

    multiword_adder_seq #(.N(8), .WORDS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(1'b1),
        .sum(sum2), .cout(cout2),
`ifdef SUB_MODE_EN
        .sub(1'b0),
`endif
        .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input wv_t act, input wv_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain wide arithmetic, result is {carry/no-borrow, sum mod 2^W}.
    function automatic wv_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        wv_t r;
        if (sv) begin
            r[W-1:0] = av - bv;
            r[W]     = (av >= bv);
        end else begin
            r = {1'b0, av} + {1'b0, bv};
        end
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: in_ready=%b, expected 1", in_ready);
        end else begin
            a = av;
            b = bv;
            sub = sv;
            in_valid = 1'b1;
            exp_q.push_back(model(av, bv, sv));
            @(posedge clk);
            #1;
            acc_q.push_back(cyc);
            in_valid = 1'b0;
            a = W'($urandom());
            b = W'($urandom());
            sub = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_outstanding", wv_t'(exp_q.size()), wv_t'(0));
    endtask

    // Monitor: latency on out_valid rise, stability while held, result on handshake.
    always @(negedge clk) begin
        int acc_v;
        if (rst_n && out_valid) begin
            if (!prev_ov) begin
                if (acc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got %h, expected none", {cout, sum});
                end else begin
                    acc_v = acc_q.pop_front();
                    check("latency", wv_t'(cyc - acc_v), wv_t'(WORDS));
                end
                held_sum  = sum;
                held_cout = cout;
            end else begin
                check("hold_stable", {cout, sum}, {held_cout, held_sum});
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL result_unexpected: got %h, expected none", {cout, sum});
                end else begin
                    check("result", {cout, sum}, exp_q.pop_front());
                end
            end
        end
        prev_ov = rst_n && out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        logic [W-1:0] bp_sum;
        logic         bp_cout;

        // Reset state
        #12;
        check("rst_in_ready", wv_t'(in_ready), wv_t'(1));
        check("rst_out_valid", wv_t'(out_valid), wv_t'(0));
        check("rst_sum", wv_t'(sum), wv_t'(0));
        check("rst_cout", wv_t'(cout), wv_t'(0));
        check("rst_busy", wv_t'(busy), wv_t'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-slice instance: 0x80 + 0x80, result one edge after accept
        @(negedge clk);
        check("w1_in_ready", wv_t'(in_ready2), wv_t'(1));
        a2 = 8'h80;
        b2 = 8'h80;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        check("w1_ov_early", wv_t'(out_valid2), wv_t'(0));
        check("w1_busy", wv_t'(busy2), wv_t'(1));
        @(posedge clk);
        #1;
        check("w1_out_valid", wv_t'(out_valid2), wv_t'(1));
        check("w1_result", {8'h00, cout2, sum2}, wv_t'(9'h100));

        // Directed adds with out_ready held high
        out_ready = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        issue(16'h0000, 16'h0000, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        drain();

        // Backpressure in DONE with in_valid toggling
        out_ready = 1'b0;
        issue(16'hABCD, 16'h1234, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", wv_t'(out_valid), wv_t'(1));
        bp_sum  = sum;
        bp_cout = cout;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = W'($urandom());
            b = W'($urandom());
            #1;
            check("bp_in_ready", wv_t'(in_ready), wv_t'(0));
            check("bp_busy", wv_t'(busy), wv_t'(1));
            check("bp_hold", {bp_cout, bp_sum}, {cout, sum});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", wv_t'(in_ready), wv_t'(1));
        check("bp_release_out_valid", wv_t'(out_valid), wv_t'(0));
        check("bp_release_busy", wv_t'(busy), wv_t'(0));
        drain();

        // Reset two RUN edges into an op, then redo it
        issue(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", wv_t'(out_valid), wv_t'(0));
        check("abort_sum", wv_t'(sum), wv_t'(0));
        check("abort_busy", wv_t'(busy), wv_t'(0));
        check("abort_in_ready", wv_t'(in_ready), wv_t'(1));
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h1234, 16'h1111, 1'b0);
        drain();

`ifdef SUB_MODE_EN
        issue(16'h0005, 16'h0007, 1'b1);
        issue(16'h0007, 16'h0005, 1'b1);
        issue(16'h1234, 16'h1234, 1'b1);
        drain();
`endif

        // Randomized operands with random consumer backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
`ifdef SUB_MODE_EN
                    issue(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
`else
                    issue(W'($urandom()), W'($urandom()), 1'b0);
`endif
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
